// File: rtl/cdb_arbiter.sv
// Common-data-bus transmit arbiter: per-FU result FIFOs feeding a 4-slot registered broadcast,
// with round-robin slot assignment so that no functional unit is starved.
module cdb_arbiter #(
    parameter int NUM_FU     = 6,
    parameter int FIFO_DEPTH = 2,
    localparam int PEND_W    = $clog2(NUM_FU * FIFO_DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_FU-1:0]      fu_valid_flat,
    input  logic [4*NUM_FU-1:0]    fu_tag_flat,
    input  logic [16*NUM_FU-1:0]   fu_value_flat,
    output logic [NUM_FU-1:0]      fu_ready_flat,
    output logic [3:0]             cdb_valid_flat,
    output logic [15:0]            cdb_indices_flat,
    output logic [63:0]            cdb_values_flat,
    output logic [PEND_W-1:0]      pending
);

    localparam int SLOTS = 4;
    localparam int TAG_W = 4;
    localparam int VAL_W = 16;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FU_W  = $clog2(NUM_FU);

    logic [NUM_FU-1:0] valid;
    logic [TAG_W-1:0]  tag_in  [NUM_FU];
    logic [VAL_W-1:0]  val_in  [NUM_FU];

    logic [TAG_W-1:0]  tag_mem_q [NUM_FU][FIFO_DEPTH];
    logic [VAL_W-1:0]  val_mem_q [NUM_FU][FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q  [NUM_FU];
    logic [PTR_W-1:0]  wr_ptr_q  [NUM_FU];
    logic [CNT_W-1:0]  count_q   [NUM_FU];
    logic [CNT_W-1:0]  count_d   [NUM_FU];
    logic [NUM_FU-1:0] ready_q;
    logic [NUM_FU-1:0] push;
    logic [NUM_FU-1:0] pop;
    logic [FU_W-1:0]   rr_ptr_q;
    logic [FU_W-1:0]   rr_ptr_d;
    logic [PEND_W-1:0] pending_q;
    logic [PEND_W-1:0] pending_d;

    logic [SLOTS-1:0]  slot_vld_d;
    logic [TAG_W-1:0]  slot_tag_d [SLOTS];
    logic [VAL_W-1:0]  slot_val_d [SLOTS];
    logic [SLOTS-1:0]  cdb_vld_q;
    logic [TAG_W-1:0]  cdb_tag_q  [SLOTS];
    logic [VAL_W-1:0]  cdb_val_q  [SLOTS];

    int idx;
    int n_grant;

    // FU k occupies the most-significant field for k=0; slot i likewise
    for (genvar k = 0; k < NUM_FU; k++) begin : g_fu
        assign valid[k]                    = fu_valid_flat[NUM_FU-1-k];
        assign tag_in[k]                   = fu_tag_flat[TAG_W*(NUM_FU-1-k) +: TAG_W];
        assign val_in[k]                   = fu_value_flat[VAL_W*(NUM_FU-1-k) +: VAL_W];
        assign fu_ready_flat[NUM_FU-1-k]   = ready_q[k];
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        assign cdb_valid_flat[SLOTS-1-s]              = cdb_vld_q[s];
        assign cdb_indices_flat[TAG_W*(SLOTS-1-s) +: TAG_W] = cdb_tag_q[s];
        assign cdb_values_flat[VAL_W*(SLOTS-1-s) +: VAL_W]  = cdb_val_q[s];
    end

    assign push    = valid & ready_q;
    assign pending = pending_q;

    always_comb begin
        pop      = '0;
        slot_vld_d = '0;
        rr_ptr_d = rr_ptr_q;
        n_grant  = 0;
        idx      = 0;
        for (int s = 0; s < SLOTS; s++) begin
            slot_tag_d[s] = '0;
            slot_val_d[s] = '0;
        end
        for (int j = 0; j < NUM_FU; j++) begin
            idx = int'(rr_ptr_q) + j;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if ((count_q[idx] != '0) && (n_grant < SLOTS)) begin
                pop[idx]            = 1'b1;
                slot_vld_d[n_grant] = 1'b1;
                slot_tag_d[n_grant] = tag_mem_q[idx][rd_ptr_q[idx]];
                slot_val_d[n_grant] = val_mem_q[idx][rd_ptr_q[idx]];
                rr_ptr_d            = (idx == NUM_FU - 1) ? '0 : FU_W'(idx + 1);
                n_grant             = n_grant + 1;
            end
        end
    end

    always_comb begin
        pending_d = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            count_d[k] = count_q[k];
            if (push[k] && !pop[k])
                count_d[k] = count_q[k] + 1'b1;
            else if (!push[k] && pop[k])
                count_d[k] = count_q[k] - 1'b1;
            pending_d = pending_d + PEND_W'(count_d[k]);
        end
    end

    // ready is registered so it stays low while reset is held and through the first edge after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_FU; k++) begin
                rd_ptr_q[k] <= '0;
                wr_ptr_q[k] <= '0;
                count_q[k]  <= '0;
            end
            for (int s = 0; s < SLOTS; s++) begin
                cdb_tag_q[s] <= '0;
                cdb_val_q[s] <= '0;
            end
            ready_q   <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            cdb_vld_q <= '0;
        end else begin
            for (int k = 0; k < NUM_FU; k++) begin
                if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + 1'b1;
                if (pop[k])  rd_ptr_q[k] <= rd_ptr_q[k] + 1'b1;
                count_q[k] <= count_d[k];
                ready_q[k] <= (count_d[k] < CNT_W'(FIFO_DEPTH));
            end
            for (int s = 0; s < SLOTS; s++) begin
                cdb_tag_q[s] <= slot_tag_d[s];
                cdb_val_q[s] <= slot_val_d[s];
            end
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            cdb_vld_q <= slot_vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_FU; k++) begin
            if (push[k]) begin
                tag_mem_q[k][wr_ptr_q[k]] <= tag_in[k];
                val_mem_q[k][wr_ptr_q[k]] <= val_in[k];
            end
        end
    end

endmodule
